// File: rtl/srl_iter.sv
// Multicycle right shifter: one bit position per clock, valid/ready on both sides.
// Define SRL_ITER_SRA_EN to enable arithmetic (sign-fill) shifts via arith.
module srl_iter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
  input  logic             arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             fill_q, fill_d;
  logic             fill_in;

`ifdef SRL_ITER_SRA_EN
  assign fill_in = arith & a[WIDTH-1];
`else
  logic unused_arith;
  assign unused_arith = arith;
  assign fill_in      = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      y_q     <= '0;
      cnt_q   <= '0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          y_d     = a;
          cnt_d   = shamt;
          fill_d  = fill_in;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          y_d   = {fill_q, y_q[WIDTH-1:1]};
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from registered state only.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign y         = y_q;

endmodule

// File: tb/tb_srl_iter.sv
// Directed self-checking bench for srl_iter.
// Expectations follow SRL_ITER_SRA_EN the same way the design does.
module tb_srl_iter;

  logic        clk;
  logic        nrst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [4:0]  shamt;
  logic        arith;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        busy;

  int total;
  int passed;
  int lat;
  int bcyc;
  logic [31:0] hold_y;

  srl_iter #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .nrst(nrst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .shamt(shamt), .arith(arith),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Accept one operand, keep in_valid high through SHIFT, wait for DONE.
  task automatic run_op(input logic [31:0] av,
                        input logic [4:0] sv,
                        input logic ar,
                        output int l,
                        output int b);
    a = av; shamt = sv; arith = ar;
    in_valid = 1'b1;
    @(posedge clk); #1;
    l = 0; b = 0;
    while (!out_valid && l < 100) begin
      if (busy) b++;
      @(posedge clk); #1;
      l++;
    end
    in_valid = 1'b0;
    a = 32'hDEAD_BEEF; shamt = 5'd7;
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_ready"}, {31'b0, in_ready}, 32'd1);
    chk({tag, "_ovld"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    total = 0; passed = 0;
    nrst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; shamt = '0; arith = 1'b0;
    #12;
    chk("rst_y", y, 32'd0);
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ovld", {31'b0, out_valid}, 32'd0);
    @(negedge clk); nrst = 1'b1;
    @(posedge clk); #1;

    // shamt=0 with out_ready held high before DONE
    out_ready = 1'b1;
    run_op(32'h2D, 5'd0, 1'b0, lat, bcyc);
    chk("s0_lat", lat, 32'd1);
    chk("s0_y", y, 32'h0000_002D);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("s0_ready", {31'b0, in_ready}, 32'd1);
    chk("s0_y_hold", y, 32'h0000_002D);

    run_op(32'h2D, 5'd2, 1'b0, lat, bcyc);
    chk("s2_lat", lat, 32'd3);
    chk("s2_busy", bcyc, 32'd3);
    chk("s2_y", y, 32'h0000_000B);
    consume("s2");

    run_op(32'h8000_0000, 5'd31, 1'b1, lat, bcyc);
    chk("s31_lat", lat, 32'd32);
`ifdef SRL_ITER_SRA_EN
    chk("s31_y", y, 32'hFFFF_FFFF);
`else
    chk("s31_y", y, 32'h0000_0001);
`endif
    consume("s31");

    run_op(32'h8000_0000, 5'd31, 1'b0, lat, bcyc);
    chk("s31l_y", y, 32'h0000_0001);
    consume("s31l");

    run_op(32'hF000_0000, 5'd4, 1'b1, lat, bcyc);
`ifdef SRL_ITER_SRA_EN
    chk("f4a_y", y, 32'hFF00_0000);
`else
    chk("f4a_y", y, 32'h0F00_0000);
`endif
    consume("f4a");

    run_op(32'hF000_0000, 5'd4, 1'b0, lat, bcyc);
    chk("f4l_lat", lat, 32'd5);
    chk("f4l_y", y, 32'h0F00_0000);
    consume("f4l");

    run_op(32'h7000_0000, 5'd4, 1'b1, lat, bcyc);
    chk("pos_arith_y", y, 32'h0700_0000);
    consume("pos");

    // backpressure with a queued operand
    run_op(32'h0000_1234, 5'd1, 1'b0, lat, bcyc);
    chk("bp_y", y, 32'h0000_091A);
    a = 32'h0000_FFFF; shamt = 5'd0; arith = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_ovld", {31'b0, out_valid}, 32'd1);
      chk("bp_ystable", y, 32'h0000_091A);
      chk("bp_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_idle", {31'b0, in_ready}, 32'd1);
    chk("bp_idle_ovld", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accept", {31'b0, busy}, 32'd1);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_q_lat", lat, 32'd1);
    chk("bp_q_y", y, 32'h0000_FFFF);
    consume("bp_q");

    // asynchronous reset mid-shift
    a = 32'hFFFF_FFFF; shamt = 5'd20; arith = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
    end
    #3 nrst = 1'b0;
    #1;
    chk("ar_ovld", {31'b0, out_valid}, 32'd0);
    chk("ar_busy", {31'b0, busy}, 32'd0);
    chk("ar_y", y, 32'd0);
    chk("ar_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk); nrst = 1'b1;
    @(posedge clk); #1;
    run_op(32'h0000_0100, 5'd8, 1'b0, lat, bcyc);
    chk("ar_post_lat", lat, 32'd9);
    chk("ar_post_y", y, 32'h0000_0001);
    consume("ar_post");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
